interrupt_source_control: RTL
=============================

Name: interrupt_source_control

Overview:
- System-side counterpart of the CPU interrupt/reset logic. Generates the CPU's RES_N, NMI_N and IRQ_N pins from peripheral requests and software commands.
- Observes CPU vector fetches (FFFA-FFFF) to identify which interrupt was taken.
- Sits between the peripherals, the CPU pins and the CPU data bus. Software accesses it as a 4-byte register window.

Parameters:
NUM_IRQ, 8, number of maskable sources (1..8)
RES_CYCLES, 8, cycles RES_N held low per reset (2..255)
NMI_LOW_CYCLES, 2, cycles NMI_N held low per NMI pulse (1..15)
NMI_HOLDOFF_CYCLES, 4, minimum NMI_N high time between pulses (1..15)

Ports:
clk_2  input  1  system clock (phase-2 domain; all state updates on rising edge)
res_p  input  1  synchronous active-high reset
irq_src  input  NUM_IRQ  peripheral interrupt requests, active high, asynchronous
nmi_req  input  1  NMI request, active high, asynchronous; rising edge triggers
cpu_addr  input  16  CPU address bus
cpu_sync  input  1  CPU opcode-fetch cycle marker
cpu_rw  input  1  CPU read/write, 1 = read
reg_sel  input  1  register window selected
reg_addr  input  2  register index
reg_wdata  input  8  write data
reg_rdata  output  8  read data
RES_N  output  1  CPU reset, active low
NMI_N  output  1  CPU NMI, active low
IRQ_N  output  1  CPU IRQ, active low
irq_ack  output  1  one-cycle pulse on IRQ/BRK vector low-byte fetch (FFFE)
nmi_ack  output  1  one-cycle pulse on NMI vector low-byte fetch (FFFA)

Behaviour:
- Clock and reset: one clock, clk_2. Reset res_p is synchronous and active-high; all flops are reset only on a clk_2 edge with res_p=1.
- Values during and after reset:
  - RES_N=0.
  - NMI_N=1, IRQ_N=1.
  - mask=0x00, pending=0, vec_id=0, ctrl=0.
  - Reset FSM enters RST_ASSERT with its counter loaded to RES_CYCLES.
  - irq_ack=0, nmi_ack=0, reg_rdata=0.
- Synchronisers: irq_src and nmi_req each pass through a 2-flop synchroniser. Request to pin latency is 3 cycles.
- Reset FSM:
  - RST_ASSERT: RES_N=0; count down to 0, then go to RST_RUN.
  - RST_RUN: RES_N=1.
  - Writing ctrl bit0=1 in RST_RUN reloads the counter and returns to RST_ASSERT. ctrl bit0 self-clears.
  - While RES_N=0: NMI FSM held in NMI_IDLE, pending cleared, vector fetches ignored. mask is preserved on a soft reset.
- NMI FSM:
  - Trigger is a synchronised nmi_req rising edge or a write of ctrl bit1=1 (self-clearing).
  - NMI_IDLE: NMI_N=1. On trigger, go to NMI_LOW.
  - NMI_LOW: NMI_N=0 for NMI_LOW_CYCLES, then go to NMI_HOLDOFF.
  - NMI_HOLDOFF: NMI_N=1 for NMI_HOLDOFF_CYCLES, then go to NMI_IDLE.
  - A trigger during NMI_LOW or NMI_HOLDOFF sets a single queued flag. On leaving HOLDOFF with the flag set, go directly to NMI_LOW and clear the flag.
  - Further triggers while the flag is already set are dropped.
  - Simultaneous edge and software trigger count as one trigger.
- IRQ:
  - pending[i] = synchronised irq_src[i] (level).
  - IRQ_N = ~|(pending & mask), registered, so 1 cycle after pending.
  - IRQ_N stays low while any enabled source is asserted.
- Vector observation:
  - Fetch condition: cpu_rw=1 && cpu_sync=0 && RES_N=1.
  - cpu_addr==FFFE → irq_ack=1 for one cycle; vec_id latches {1'b1, 4'b0, index of lowest-numbered set bit of pending&mask} (bit7=0 if none).
  - cpu_addr==FFFA → nmi_ack=1 for one cycle; vec_id latches 0x40.
  - FFFC is ignored.
- Register map:
  - Reads return registered data one cycle after reg_sel&&cpu_rw.
  - Writes are accepted when reg_sel && !cpu_rw.
  - 0 mask: R/W; bits ≥ NUM_IRQ read 0 and ignore writes.
  - 1 pending: R; writes ignored (see option).
  - 2 vec_id: R; reading clears it to 0.
  - 3 ctrl: W bit0 soft reset, bit1 software NMI. Reads return {5'b0, nmi_queued, NMI_N==0, RES_N==0}.
- Precedence: res_p overrides everything. A soft-reset write wins over a simultaneous NMI trigger; the NMI is dropped.

Optional Feature:
- Macro: IRQ_EDGE_EN.
- Defined:
  - Adds register 1 write semantics: write-1-to-clear.
  - Adds edge_mode register at index 1 upper alias, via ctrl bit7 select: when ctrl bit7=1, reg_addr 1 accesses edge_mode R/W.
  - For edge_mode[i]=1, pending[i] sets on the synchronised rising edge and holds until cleared by a write of 1. Set wins over a simultaneous clear.
  - Level-mode bits behave as in the base design.
- Undefined: all sources are level-only; ctrl bit7 is ignored and reads 0; writes to register 1 have no effect.

Test Plan:
- res_p=1 for 1 cycle → RES_N low exactly 8 cycles after release then high; NMI_N=1, IRQ_N=1, mask reads 0x00.
- mask=0x05; irq_src=0x04 → IRQ_N=0 after 3 cycles. Read at FFFE → irq_ack pulse, vec_id=0x82. Drop irq_src → IRQ_N=1 after 3 cycles.
- Two nmi_req edges 1 cycle apart → NMI_N low 2, high 4, low 2 cycles. A third edge during the second low is queued and produces a third pulse. nmi_ack and vec_id=0x40 on an FFFA read.
- Write ctrl=0x01 mid NMI_LOW → NMI_N=1 next cycle, RES_N low 8 cycles, mask preserved, pending=0.
- irq_src=0x03, mask=0xFF, FFFE fetch → vec_id=0x80 (lowest index wins). Reading register 2 twice returns 0x80 then 0x00.
- (IRQ_EDGE_EN) edge_mode=0x01; pulse irq_src[0] for 1 cycle → pending[0] stays set and IRQ_N=0. Write 0x01 to register 1 → IRQ_N=1.

Source files
------------

// File: rtl/interrupt_source_control_if.sv
// CPU-side bus bundle for interrupt_source_control: address/strobe lines seen by
// vector observation plus the 4-byte register window.
interface interrupt_source_control_if;
    logic [15:0] cpu_addr;
    logic        cpu_sync;
    logic        cpu_rw;
    logic        reg_sel;
    logic [1:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;

    modport master (
        output cpu_addr, cpu_sync, cpu_rw, reg_sel, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  cpu_addr, cpu_sync, cpu_rw, reg_sel, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/interrupt_source_control.sv
// Generates CPU RES_N/NMI_N/IRQ_N from peripheral requests and register commands.
// Optional macro IRQ_EDGE_EN adds per-source edge-latched pending with write-1-to-clear.
module interrupt_source_control #(
    parameter int NUM_IRQ            = 8,
    parameter int RES_CYCLES         = 8,
    parameter int NMI_LOW_CYCLES     = 2,
    parameter int NMI_HOLDOFF_CYCLES = 4
) (
    input  logic                  clk_2,
    input  logic                  res_p,
    input  logic [NUM_IRQ-1:0]    irq_src,
    input  logic                  nmi_req,
    interrupt_source_control_if.slave bus,
    output logic                  RES_N,
    output logic                  NMI_N,
    output logic                  IRQ_N,
    output logic                  irq_ack,
    output logic                  nmi_ack
);
    // state        | meaning
    // RST_ASSERT   | RES_N driven low, counting down the reset pulse
    // RST_RUN      | RES_N high, CPU running
    // NMI_IDLE     | NMI_N high, waiting for a trigger
    // NMI_LOW      | NMI_N low for NMI_LOW_CYCLES
    // NMI_HOLDOFF  | NMI_N high for NMI_HOLDOFF_CYCLES before another pulse

    // Encodings chosen so RES_N and NMI_N come straight off a state flop.
    localparam logic       RST_ASSERT  = 1'b0;
    localparam logic       RST_RUN     = 1'b1;
    localparam logic [1:0] NMI_IDLE    = 2'b00;
    localparam logic [1:0] NMI_LOW     = 2'b01;
    localparam logic [1:0] NMI_HOLDOFF = 2'b10;

    localparam logic [7:0] SRC_VALID     = 8'((16'd1 << NUM_IRQ) - 16'd1);
    localparam logic [7:0] RES_LOAD      = 8'(RES_CYCLES);
    localparam logic [3:0] NMI_LOW_LOAD  = 4'(NMI_LOW_CYCLES);
    localparam logic [3:0] NMI_HOLD_LOAD = 4'(NMI_HOLDOFF_CYCLES);

    logic [7:0] irq_s1_q, irq_s2_q;
    logic       nmi_s1_q, nmi_s2_q, nmi_s3_q;
    logic       rst_state_q, rst_state_d;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic [1:0] nmi_state_q, nmi_state_d;
    logic [3:0] nmi_cnt_q, nmi_cnt_d;
    logic       nmi_queued_q, nmi_queued_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] vec_id_q, vec_id_d;
    logic       irq_n_q, irq_n_d;
    logic       irq_ack_q, irq_ack_d;
    logic       nmi_ack_q, nmi_ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic       edge_sel_q, edge_sel_d;

    logic       run, wr_en, rd_en, wr_ctrl, soft_rst, sw_nmi, nmi_trig, fetch;
    logic [7:0] pending, active;
    logic [2:0] lowest_idx;

    assign run      = (rst_state_q == RST_RUN);
    assign wr_en    = bus.reg_sel & ~bus.cpu_rw;
    assign rd_en    = bus.reg_sel &  bus.cpu_rw;
    assign wr_ctrl  = wr_en && (bus.reg_addr == 2'd3);
    assign soft_rst = wr_ctrl && bus.reg_wdata[0] && run;
    assign sw_nmi   = wr_ctrl && bus.reg_wdata[1];
    assign nmi_trig = (nmi_s2_q & ~nmi_s3_q) | sw_nmi;
    assign fetch    = bus.cpu_rw & ~bus.cpu_sync & run;

`ifdef IRQ_EDGE_EN
    logic [7:0] irq_s3_q;
    logic [7:0] edge_mode_q, edge_mode_d;
    logic [7:0] edge_pend_q, edge_pend_d;
    logic [7:0] edge_clr;

    assign pending = run ? (((edge_mode_q & edge_pend_q) | (~edge_mode_q & irq_s2_q)) & SRC_VALID)
                         : 8'h00;

    always_comb begin
        edge_sel_d  = edge_sel_q;
        edge_mode_d = edge_mode_q;
        edge_clr    = 8'h00;
        if (wr_ctrl) begin
            edge_sel_d = bus.reg_wdata[7];
        end
        if (wr_en && (bus.reg_addr == 2'd1)) begin
            if (edge_sel_q) begin
                edge_mode_d = bus.reg_wdata & SRC_VALID;
            end else begin
                edge_clr = bus.reg_wdata & SRC_VALID;
            end
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        edge_pend_d = run ? (((irq_s2_q & ~irq_s3_q) | (edge_pend_q & ~edge_clr)) & edge_mode_q)
                          : 8'h00;
    end

    always_ff @(posedge clk_2) begin
        if (res_p) begin
            irq_s3_q    <= 8'h00;
            edge_mode_q <= 8'h00;
            edge_pend_q <= 8'h00;
        end else begin
            irq_s3_q    <= irq_s2_q;
            edge_mode_q <= edge_mode_d;
            edge_pend_q <= edge_pend_d;
        end
    end
`else
    assign pending    = run ? (irq_s2_q & SRC_VALID) : 8'h00;
    assign edge_sel_d = 1'b0;
`endif

    assign active = pending & mask_q;

    always_comb begin
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                lowest_idx = 3'(i);
            end
        end
    end

    always_comb begin
        rst_state_d = rst_state_q;
        rst_cnt_d   = rst_cnt_q;
        case (rst_state_q)
            RST_ASSERT: begin
                if (rst_cnt_q <= 8'd1) begin
                    rst_state_d = RST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - 8'd1;
                end
            end
            default: begin
                if (soft_rst) begin
                    rst_state_d = RST_ASSERT;
                    rst_cnt_d   = RES_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        nmi_state_d  = nmi_state_q;
        nmi_cnt_d    = nmi_cnt_q;
        nmi_queued_d = nmi_queued_q;
        if (!run || soft_rst) begin
            nmi_state_d  = NMI_IDLE;
            nmi_cnt_d    = 4'd0;
            nmi_queued_d = 1'b0;
        end else begin
            case (nmi_state_q)
                NMI_IDLE: begin
                    if (nmi_trig) begin
                        nmi_state_d = NMI_LOW;
                        nmi_cnt_d   = NMI_LOW_LOAD;
                    end
                end
                NMI_LOW: begin
                    if (nmi_trig) begin
                        nmi_queued_d = 1'b1;
                    end
                    if (nmi_cnt_q <= 4'd1) begin
                        nmi_state_d = NMI_HOLDOFF;
                        nmi_cnt_d   = NMI_HOLD_LOAD;
                    end else begin
                        nmi_cnt_d = nmi_cnt_q - 4'd1;
                    end
                end
                NMI_HOLDOFF: begin
                    // A trigger on the final holdoff cycle is served like a queued one.
                    if (nmi_cnt_q <= 4'd1) begin
                        if (nmi_queued_q || nmi_trig) begin
                            nmi_state_d  = NMI_LOW;
                            nmi_cnt_d    = NMI_LOW_LOAD;
                            nmi_queued_d = 1'b0;
                        end else begin
                            nmi_state_d = NMI_IDLE;
                        end
                    end else begin
                        nmi_cnt_d = nmi_cnt_q - 4'd1;
                        if (nmi_trig) begin
                            nmi_queued_d = 1'b1;
                        end
                    end
                end
                default: begin
                    nmi_state_d = NMI_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        irq_n_d   = ~|active;
        mask_d    = mask_q;
        vec_id_d  = vec_id_q;
        irq_ack_d = fetch && (bus.cpu_addr == 16'hFFFE);
        nmi_ack_d = fetch && (bus.cpu_addr == 16'hFFFA);
        rdata_d   = 8'h00;

        if (wr_en && (bus.reg_addr == 2'd0)) begin
            mask_d = bus.reg_wdata & SRC_VALID;
        end

        if (rd_en) begin
            case (bus.reg_addr)
                2'd0: rdata_d = mask_q;
`ifdef IRQ_EDGE_EN
                2'd1: rdata_d = edge_sel_q ? edge_mode_q : pending;
`else
                2'd1: rdata_d = pending;
`endif
                2'd2: rdata_d = vec_id_q;
                default: rdata_d = {edge_sel_q, 4'b0000, nmi_queued_q,
                                    (nmi_state_q == NMI_LOW), ~run};
            endcase
            if (bus.reg_addr == 2'd2) begin
                vec_id_d = 8'h00;
            end
        end

        // A vector fetch in the same cycle as a vec_id read keeps the new id.
        if (irq_ack_d) begin
            vec_id_d = (|active) ? {1'b1, 4'b0000, lowest_idx} : 8'h00;
        end else if (nmi_ack_d) begin
            vec_id_d = 8'h40;
        end
    end

    always_ff @(posedge clk_2) begin
        if (res_p) begin
            irq_s1_q     <= 8'h00;
            irq_s2_q     <= 8'h00;
            nmi_s1_q     <= 1'b0;
            nmi_s2_q     <= 1'b0;
            nmi_s3_q     <= 1'b0;
            rst_state_q  <= RST_ASSERT;
            rst_cnt_q    <= RES_LOAD;
            nmi_state_q  <= NMI_IDLE;
            nmi_cnt_q    <= 4'd0;
            nmi_queued_q <= 1'b0;
            mask_q       <= 8'h00;
            vec_id_q     <= 8'h00;
            irq_n_q      <= 1'b1;
            irq_ack_q    <= 1'b0;
            nmi_ack_q    <= 1'b0;
            rdata_q      <= 8'h00;
            edge_sel_q   <= 1'b0;
        end else begin
            irq_s1_q     <= 8'(irq_src);
            irq_s2_q     <= irq_s1_q;
            nmi_s1_q     <= nmi_req;
            nmi_s2_q     <= nmi_s1_q;
            nmi_s3_q     <= nmi_s2_q;
            rst_state_q  <= rst_state_d;
            rst_cnt_q    <= rst_cnt_d;
            nmi_state_q  <= nmi_state_d;
            nmi_cnt_q    <= nmi_cnt_d;
            nmi_queued_q <= nmi_queued_d;
            mask_q       <= mask_d;
            vec_id_q     <= vec_id_d;
            irq_n_q      <= irq_n_d;
            irq_ack_q    <= irq_ack_d;
            nmi_ack_q    <= nmi_ack_d;
            rdata_q      <= rdata_d;
            edge_sel_q   <= edge_sel_d;
        end
    end

    assign RES_N         = rst_state_q;
    assign NMI_N         = ~nmi_state_q[0];
    assign IRQ_N         = irq_n_q;
    assign irq_ack       = irq_ack_q;
    assign nmi_ack       = nmi_ack_q;
    assign bus.reg_rdata = rdata_q;
endmodule
